issue_scoreboard: RTL
=====================

// Module: issue_scoreboard
// PURPOSE
//  Parametrised in-order issue stage between decode and execute. Holds one instruction.
//  Owns the register file and a per-register busy scoreboard. Stalls on RAW/WAW hazards.
//  Issues operands plus control to execute over a valid/ready handshake.
// PARAMETERS
//  XLEN   32  operand/register data width
//  NREGS  32  architectural registers; AW = $clog2(NREGS); x0 reads 0, never written/busy
//  IMMW   12  immediate width (sign-extended to XLEN)
// PORTS
//  clk        in   1     clock, rising edge
//  nrst       in   1     reset, asynchronous, active-low
//  dec_valid  in   1     decode presents an instruction
//  dec_ready  out  1     stage can accept an instruction this cycle
//  rs1,rs2    in   AW    source register addresses
//  rd_d       in   AW    destination address
//  we_d,fn_d  in   1     write-enable / function-select controls from decode
//  alu_fn_d   in   4     ALU control from decode
//  B_SEL      in   2     00 reg rs2, 01 sign-ext imm, 10 zero-ext shamt, 11 reg rs2
//  imm        in   IMMW  immediate
//  shamt      in   5     shift amount
//  we_c       in   1     commit writeback enable
//  rdaddr     in   AW    commit writeback address
//  wb_d       in   XLEN  commit writeback data
//  iss_valid  out  1     op_a/op_b/controls valid toward execute
//  iss_ready  in   1     execute accepts
//  op_a,op_b  out  XLEN  operands
//  rd         out  AW    destination to execute
//  alu_fn     out  4     ALU control
//  fn,we      out  1     function select, write enable
// BEHAVIOUR
//  - Reset (async, nrst=0): hold_valid=0; busy=0; all regs=0; held fields=0.
//    Outputs: iss_valid=0, dec_ready=1, op_a=op_b=0, rd=0, alu_fn=0, fn=0, we=0.
//    Mid-operation reset discards the held instruction and clears all busy bits.
//  - Accept: dec_valid&&dec_ready latches all decode fields; hold_valid<=1.
//  - dec_ready = !hold_valid || fire. Back-to-back issue gives 1 instr/cycle.
//  - fire = iss_valid && iss_ready. On fire without a new accept: hold_valid<=0.
//  - Latency: accepted at edge N -> iss_valid high in cycle N+1 if no hazard.
//  - Outputs are combinational from the holding register, scoreboard, and regfile read ports.
//  - Hazard, where any of the following is true:
//    - hz_a = busy[rs1] (rs1!=0);
//    - hz_b = busy[rs2] (rs2!=0, B_SEL in {00,11});
//    - hz_w = we && busy[rd] (rd!=0; one outstanding write per reg).
//  - iss_valid = hold_valid && !(hz_a||hz_b||hz_w).
//  - iss_valid, once high, holds until fire unless reset. Held fields are stable while iss_valid && !iss_ready.
//  - Scoreboard:
//    - Set busy[rd] on fire with we && rd!=0.
//    - Clear busy[rdaddr] on we_c (rdaddr!=0).
//    - Same reg set and cleared in one cycle -> set wins.
//  - Regfile: synchronous write at rising edge when we_c && rdaddr!=0.
//    Writes to x0 are ignored. Reads are asynchronous.
//  - op_b:
//    - 01 = {{XLEN-IMMW{imm[IMMW-1]}},imm};
//    - 10 = {{XLEN-5{0}},shamt};
//    - 00/11 = reg[rs2].
// CONFIGURATION
//  ISSUE_BYPASS_EN defined:
//    - Same-cycle commit bypass. When we_c && rdaddr==rs1 (!=0), op_a=wb_d and hz_a is suppressed.
//    - The same applies to rs2 / hz_b when B_SEL selects the register.
//    - hz_w is suppressed when rdaddr==rd.
//  ISSUE_BYPASS_EN undefined:
//    - No bypass. The hazard persists through the commit cycle.
//    - Issue happens the cycle after commit and reads the new regfile value.
// TESTING
//  1. Reset: nrst=0 mid-stall -> iss_valid=0, dec_ready=1, busy all 0, op_a=op_b=0.
//  2. Independent stream: addi x1,x0,-1 (imm=12'hFFF, B_SEL=01), then x2 op.
//     Expect op_b=32'hFFFF_FFFF, 1 issue/cycle, dec_ready never low.
//  3. RAW: issue x5 producer (we=1); next instr rs1=x5 -> iss_valid=0.
//     Commit we_c,rdaddr=5,wb_d=0xA5:
//     - bypass: issue same cycle, op_a=0xA5;
//     - no bypass: next cycle, op_a=0xA5.
//  4. Backpressure: iss_ready=0 for 3 cycles with iss_valid=1 -> outputs stable, dec_ready=0.
//     Then the held instr fires and the new instr is accepted the same cycle.
//  5. x0 rules:
//     - we_c rdaddr=0 wb_d=0x55 -> reg[0] stays 0;
//     - rd=0 we=1 fire -> no busy set, no WAW stall.
//  6. WAW + collision: rd=x7 busy; instr writing x7 stalls until commit x7.
//     Set/clear of x7 in the same cycle -> busy[x7]=1 afterwards.

Source files
------------

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - in-order issue stage with regfile, busy scoreboard and RAW/WAW stall
// Optional same-cycle commit bypass: ISSUE_BYPASS_EN
module issue_scoreboard #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int IMMW  = 12,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd_d,
    input  logic            we_d,
    input  logic            fn_d,
    input  logic [3:0]      alu_fn_d,
    input  logic [1:0]      B_SEL,
    input  logic [IMMW-1:0] imm,
    input  logic [4:0]      shamt,
    input  logic            we_c,
    input  logic [AW-1:0]   rdaddr,
    input  logic [XLEN-1:0] wb_d,
    output logic            iss_valid,
    input  logic            iss_ready,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic [AW-1:0]   rd,
    output logic [3:0]      alu_fn,
    output logic            fn,
    output logic            we
);

    logic            hold_valid_q, hold_valid_d;
    logic [AW-1:0]   rs1_q, rs2_q, rd_q;
    logic            we_q, fn_q;
    logic [3:0]      alu_fn_q;
    logic [1:0]      b_sel_q;
    logic [IMMW-1:0] imm_q;
    logic [4:0]      shamt_q;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [XLEN-1:0] regs_q [NREGS];

    logic accept, fire, commit, b_is_reg;
    logic hz_a, hz_b, hz_w;
    logic byp_a, byp_b, byp_w;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign commit   = we_c && (rdaddr != '0);
    assign b_is_reg = (b_sel_q == 2'b00) || (b_sel_q == 2'b11);

`ifdef ISSUE_BYPASS_EN
    assign byp_a = commit && (rdaddr == rs1_q);
    assign byp_b = commit && (rdaddr == rs2_q);
    assign byp_w = commit && (rdaddr == rd_q);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
    assign byp_w = 1'b0;
`endif

    assign hz_a = (rs1_q != '0) && busy_q[rs1_q] && !byp_a;
    assign hz_b = b_is_reg && (rs2_q != '0) && busy_q[rs2_q] && !byp_b;
    assign hz_w = we_q && (rd_q != '0) && busy_q[rd_q] && !byp_w;

    assign iss_valid = hold_valid_q && !(hz_a || hz_b || hz_w);
    assign fire      = iss_valid && iss_ready;
    assign dec_ready = !hold_valid_q || fire;
    assign accept    = dec_valid && dec_ready;

    // x0 is never written, so reading regs_q[0] already yields zero
    always_comb begin
        rs1_val = byp_a ? wb_d : regs_q[rs1_q];
        rs2_val = byp_b ? wb_d : regs_q[rs2_q];
        op_a    = rs1_val;
        case (b_sel_q)
            2'b01:   op_b = {{(XLEN-IMMW){imm_q[IMMW-1]}}, imm_q};
            2'b10:   op_b = {{(XLEN-5){1'b0}}, shamt_q};
            default: op_b = rs2_val;
        endcase
    end

    assign rd     = rd_q;
    assign alu_fn = alu_fn_q;
    assign fn     = fn_q;
    assign we     = we_q;

    always_comb begin
        hold_valid_d = hold_valid_q;
        if (accept)    hold_valid_d = 1'b1;
        else if (fire) hold_valid_d = 1'b0;
    end

    // Clear first so an issue setting the same register in this cycle wins
    always_comb begin
        busy_d = busy_q;
        if (commit)                      busy_d[rdaddr] = 1'b0;
        if (fire && we_q && rd_q != '0)  busy_d[rd_q]   = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hold_valid_q <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            we_q         <= 1'b0;
            fn_q         <= 1'b0;
            alu_fn_q     <= '0;
            b_sel_q      <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            busy_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            busy_q       <= busy_d;
            if (accept) begin
                rs1_q    <= rs1;
                rs2_q    <= rs2;
                rd_q     <= rd_d;
                we_q     <= we_d;
                fn_q     <= fn_d;
                alu_fn_q <= alu_fn_d;
                b_sel_q  <= B_SEL;
                imm_q    <= imm;
                shamt_q  <= shamt;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (commit) begin
            regs_q[rdaddr] <= wb_d;
        end
    end

endmodule
